// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with EX/MEM + MEM/WB operand forwarding and load-use bubble insertion.
// Optional saturating bubble counter port is enabled by defining ALU_STAGE_PERF_EN.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;
   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;
endpackage

module alu_operand_stage
   import cpu_types_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic     CLK,
   input  logic     nRST,
   input  logic     dec_valid,
   output logic     dec_ready,
   input  aluop_t   dec_aluop,
   input  regbits_t dec_rs,
   input  regbits_t dec_rt,
   input  word_t    dec_rs_data,
   input  word_t    dec_rt_data,
   input  word_t    dec_imm,
   input  logic     dec_alusrc,
   input  logic     dec_wen,
   input  regbits_t dec_wsel,
   input  logic     dec_memread,
   input  logic     exm_wen,
   input  regbits_t exm_wsel,
   input  word_t    exm_data,
   input  logic     mwb_wen,
   input  regbits_t mwb_wsel,
   input  word_t    mwb_data,
   input  logic     stall,
   input  logic     flush,
   output logic     ex_valid,
   output logic     ex_wen,
   output regbits_t ex_wsel,
   output logic     ex_memread,
   output aluop_t   alu_op,
   output word_t    alu_port_a,
   output word_t    alu_port_b,
   output word_t    ex_rt_fwd
`ifdef ALU_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   if (LU_BUBBLES < 1 || LU_BUBBLES > 3 || CNT_W < 1) begin : g_param_check
      $error("alu_operand_stage: LU_BUBBLES must be 1..3 and CNT_W >= 1");
   end

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

   localparam logic [1:0] CNT_INIT = 2'(LU_BUBBLES - 1);

   state_t     state_r, state_nxt_s;
   logic [1:0] cnt_r, cnt_nxt_s;
   logic       hazard_s, bubble_go_s, accept_s;
   regbits_t   rs_r, rt_r;
   word_t      rs_data_r, rt_data_r, imm_r;
   logic       alusrc_r;
   word_t      fwd_rs_s, fwd_rt_s;

   // A retiring MEM/WB write to a live source register replaces the captured/held operand.
   function automatic logic wb_hit(input logic wen, input regbits_t wsel, input regbits_t idx);
      return wen && (idx != 5'd0) && (wsel == idx);
   endfunction

   function automatic word_t fwd_sel(input regbits_t idx, input word_t held,
                                     input logic e_wen, input regbits_t e_wsel, input word_t e_data,
                                     input logic w_wen, input regbits_t w_wsel, input word_t w_data);
      word_t res;
      if (idx == 5'd0)                          res = held;
      else if (e_wen && (e_wsel == idx))        res = e_data;
      else if (w_wen && (w_wsel == idx))        res = w_data;
      else                                      res = held;
      return res;
   endfunction

   assign hazard_s = ex_valid && ex_memread && ex_wen && (ex_wsel != 5'd0) &&
                     ((ex_wsel == dec_rs) || (ex_wsel == dec_rt));

   // Bubble FSM state and countdown register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= ST_IDLE;
         cnt_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Bubble FSM next state: flush aborts, stall freezes the countdown.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (!flush && !stall && hazard_s && dec_valid) begin
               state_nxt_s = ST_BUBBLE;
               cnt_nxt_s   = CNT_INIT;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = cnt_r;
            end
         end
         ST_BUBBLE: begin
            if (flush) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 2'd0;
            end else if (stall) begin
               state_nxt_s = ST_BUBBLE;
               cnt_nxt_s   = cnt_r;
            end else if (cnt_r == 2'd0) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 2'd0;
            end else begin
               state_nxt_s = ST_BUBBLE;
               cnt_nxt_s   = cnt_r - 2'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 2'd0;
         end
      endcase
   end

   // Handshake outputs; a flushed cycle never accepts even if dec_ready is high.
   always_comb begin
      dec_ready   = 1'b0;
      bubble_go_s = 1'b0;
      if (state_r == ST_IDLE) begin
         dec_ready   = !stall && !hazard_s;
         bubble_go_s = hazard_s && dec_valid && !stall && !flush;
      end else begin
         dec_ready   = 1'b0;
         bubble_go_s = 1'b0;
      end
      accept_s = dec_valid && dec_ready && !flush && !bubble_go_s;
   end

   // ID/EX register: capture on accept, otherwise hold data and track MEM/WB writes.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ex_valid   <= 1'b0;
         ex_wen     <= 1'b0;
         ex_wsel    <= 5'd0;
         ex_memread <= 1'b0;
         alu_op     <= aluop_t'(4'd0);
         rs_r       <= 5'd0;
         rt_r       <= 5'd0;
         rs_data_r  <= 32'd0;
         rt_data_r  <= 32'd0;
         imm_r      <= 32'd0;
         alusrc_r   <= 1'b0;
      end else if (accept_s) begin
         ex_valid   <= 1'b1;
         ex_wen     <= dec_wen;
         ex_wsel    <= dec_wsel;
         ex_memread <= dec_memread;
         alu_op     <= dec_aluop;
         rs_r       <= dec_rs;
         rt_r       <= dec_rt;
         rs_data_r  <= wb_hit(mwb_wen, mwb_wsel, dec_rs) ? mwb_data : dec_rs_data;
         rt_data_r  <= wb_hit(mwb_wen, mwb_wsel, dec_rt) ? mwb_data : dec_rt_data;
         imm_r      <= dec_imm;
         alusrc_r   <= dec_alusrc;
      end else begin
         ex_valid   <= (stall && !flush) ? ex_valid : 1'b0;
         rs_data_r  <= wb_hit(mwb_wen, mwb_wsel, rs_r) ? mwb_data : rs_data_r;
         rt_data_r  <= wb_hit(mwb_wen, mwb_wsel, rt_r) ? mwb_data : rt_data_r;
      end
   end

   // Operand forwarding on registered indices; EX/MEM has priority over MEM/WB.
   always_comb begin
      fwd_rs_s  = fwd_sel(rs_r, rs_data_r, exm_wen, exm_wsel, exm_data, mwb_wen, mwb_wsel, mwb_data);
      fwd_rt_s  = fwd_sel(rt_r, rt_data_r, exm_wen, exm_wsel, exm_data, mwb_wen, mwb_wsel, mwb_data);
      alu_port_a = fwd_rs_s;
      ex_rt_fwd  = fwd_rt_s;
      if (alusrc_r) begin
         alu_port_b = imm_r;
      end else begin
         alu_port_b = fwd_rt_s;
      end
   end

`ifdef ALU_STAGE_PERF_EN
   // Saturating count of cycles spent in the bubble state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bubble_cnt <= '0;
      end else if ((state_r == ST_BUBBLE) && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
         bubble_cnt <= bubble_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: constant vector table, directed corner sequences,
// and randomized traffic checked against a cycle-level reference model of the stage.
module tb_alu_operand_stage;
   import cpu_types_pkg::*;

   localparam int LU = 1;
   localparam int CW = 16;

   logic     CLK = 1'b0;
   logic     nRST;
   logic     dec_valid, dec_ready;
   aluop_t   dec_aluop;
   regbits_t dec_rs, dec_rt, dec_wsel;
   word_t    dec_rs_data, dec_rt_data, dec_imm;
   logic     dec_alusrc, dec_wen, dec_memread;
   logic     exm_wen, mwb_wen;
   regbits_t exm_wsel, mwb_wsel;
   word_t    exm_data, mwb_data;
   logic     stall, flush;
   logic     ex_valid, ex_wen, ex_memread;
   regbits_t ex_wsel;
   aluop_t   alu_op;
   word_t    alu_port_a, alu_port_b, ex_rt_fwd;
`ifdef ALU_STAGE_PERF_EN
   logic [CW-1:0] bubble_cnt;
`endif

   alu_operand_stage #(.LU_BUBBLES(LU), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_aluop(dec_aluop),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rs_data(dec_rs_data), .dec_rt_data(dec_rt_data),
      .dec_imm(dec_imm), .dec_alusrc(dec_alusrc), .dec_wen(dec_wen), .dec_wsel(dec_wsel),
      .dec_memread(dec_memread),
      .exm_wen(exm_wen), .exm_wsel(exm_wsel), .exm_data(exm_data),
      .mwb_wen(mwb_wen), .mwb_wsel(mwb_wsel), .mwb_data(mwb_data),
      .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_wsel(ex_wsel), .ex_memread(ex_memread),
      .alu_op(alu_op), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .ex_rt_fwd(ex_rt_fwd)
`ifdef ALU_STAGE_PERF_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: contents of the EX slot and remaining bubble cycles.
   typedef struct packed {
      logic     valid;
      aluop_t   op;
      regbits_t rs, rt;
      word_t    rsd, rtd, imm;
      logic     alusrc, wen;
      regbits_t wsel;
      logic     memread;
   } ex_t;

   ex_t m;
   int  bub_left = 0;
   int  bub_seen = 0;
   int  total = 0;
   int  bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic word_t fwd(input regbits_t idx, input word_t held);
      if (idx == 5'd0) return held;
      if (exm_wen && exm_wsel == idx) return exm_data;
      if (mwb_wen && mwb_wsel == idx) return mwb_data;
      return held;
   endfunction

   function automatic word_t wb_snoop(input regbits_t idx, input word_t d);
      return (mwb_wen && idx != 5'd0 && mwb_wsel == idx) ? mwb_data : d;
   endfunction

   task automatic m_reset();
      m        = '0;
      bub_left = 0;
      bub_seen = 0;
   endtask

   task automatic idle_in();
      dec_valid = 1'b0; dec_aluop = ALU_SLL; dec_rs = 5'd0; dec_rt = 5'd0;
      dec_rs_data = 32'd0; dec_rt_data = 32'd0; dec_imm = 32'd0;
      dec_alusrc = 1'b0; dec_wen = 1'b0; dec_wsel = 5'd0; dec_memread = 1'b0;
      exm_wen = 1'b0; exm_wsel = 5'd0; exm_data = 32'd0;
      mwb_wen = 1'b0; mwb_wsel = 5'd0; mwb_data = 32'd0;
      stall = 1'b0; flush = 1'b0;
   endtask

   // One clock: compare DUT against the model at negedge, then advance the model at posedge.
   task automatic tick();
      logic  haz, rdy, busy;
      word_t ea, er, eb;
      @(negedge CLK);
      busy = (bub_left > 0);
      haz  = m.valid && m.memread && m.wen && (m.wsel != 5'd0) &&
             ((m.wsel == dec_rs) || (m.wsel == dec_rt));
      rdy  = !stall && !haz && !busy;
      ea   = fwd(m.rs, m.rsd);
      er   = fwd(m.rt, m.rtd);
      eb   = m.alusrc ? m.imm : er;
      chk("model dec_ready", 32'(dec_ready), 32'(rdy));
      chk("model ex_valid", 32'(ex_valid), 32'(m.valid));
      if (m.valid) begin
         chk("model alu_op", 32'(alu_op), 32'(m.op));
         chk("model port_a", alu_port_a, ea);
         chk("model port_b", alu_port_b, eb);
         chk("model rt_fwd", ex_rt_fwd, er);
         chk("model dest", {25'd0, ex_wen, ex_memread, ex_wsel}, {25'd0, m.wen, m.memread, m.wsel});
      end
      @(posedge CLK);
      if (busy) bub_seen++;
      if (flush) begin
         m.valid = 1'b0; bub_left = 0;
         m.rsd = wb_snoop(m.rs, m.rsd); m.rtd = wb_snoop(m.rt, m.rtd);
      end else if (stall) begin
         m.rsd = wb_snoop(m.rs, m.rsd); m.rtd = wb_snoop(m.rt, m.rtd);
      end else if (busy) begin
         bub_left--; m.valid = 1'b0;
         m.rsd = wb_snoop(m.rs, m.rsd); m.rtd = wb_snoop(m.rt, m.rtd);
      end else if (haz && dec_valid) begin
         bub_left = LU; m.valid = 1'b0;
         m.rsd = wb_snoop(m.rs, m.rsd); m.rtd = wb_snoop(m.rt, m.rtd);
      end else if (dec_valid && rdy) begin
         m.valid = 1'b1; m.op = dec_aluop; m.rs = dec_rs; m.rt = dec_rt;
         m.rsd = wb_snoop(dec_rs, dec_rs_data); m.rtd = wb_snoop(dec_rt, dec_rt_data);
         m.imm = dec_imm; m.alusrc = dec_alusrc; m.wen = dec_wen; m.wsel = dec_wsel;
         m.memread = dec_memread;
      end else begin
         m.valid = 1'b0;
         m.rsd = wb_snoop(m.rs, m.rsd); m.rtd = wb_snoop(m.rt, m.rtd);
      end
      #1;
   endtask

   task automatic load_use(input regbits_t r, input word_t v);
      idle_in(); dec_valid = 1'b1; dec_memread = 1'b1; dec_wen = 1'b1; dec_wsel = r; dec_rs = 5'd1;
      tick();
      dec_memread = 1'b0; dec_wsel = 5'd6; dec_rs = r; dec_rt = 5'd1;
      tick();
      tick();
      mwb_wen = 1'b1; mwb_wsel = r; mwb_data = v;
      tick();
      idle_in();
      tick();
   endtask

   typedef struct {
      regbits_t rs, rt;
      word_t    rsd, rtd, imm;
      logic     alusrc;
      logic     e_wen;  regbits_t e_sel;  word_t e_data;
      logic     w_wen;  regbits_t w_sel;  word_t w_data;
      word_t    exp_a, exp_b, exp_rtf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{5'd7, 5'd2, 32'h1,  32'h2,  32'h10,  1'b0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 32'hAAAA, 32'h2,    32'h2};
      vecs[1] = '{5'd7, 5'd2, 32'h1,  32'h2,  32'h10,  1'b0, 1'b0, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 32'h5555, 32'h2,    32'h2};
      vecs[2] = '{5'd0, 5'd2, 32'h0,  32'h2,  32'h10,  1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h0,    32'h2,    32'h2};
      vecs[3] = '{5'd3, 5'd4, 32'h33, 32'h4,  32'h100, 1'b1, 1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 32'h0,    32'h33,   32'h100,  32'h44};
      vecs[4] = '{5'd3, 5'd4, 32'h33, 32'h4,  32'h100, 1'b0, 1'b1, 5'd5, 32'h99,   1'b1, 5'd4, 32'h77,   32'h33,   32'h77,   32'h77};
      vecs[5] = '{5'd9, 5'd9, 32'h1,  32'h2,  32'h0,   1'b0, 1'b1, 5'd9, 32'hC0DE, 1'b0, 5'd0, 32'h0,    32'hC0DE, 32'hC0DE, 32'hC0DE};
      vecs[6] = '{5'd8, 5'd1, 32'h88, 32'h11, 32'h0,   1'b0, 1'b0, 5'd8, 32'hF00D, 1'b0, 5'd1, 32'hF11D, 32'h88,   32'h11,   32'h11};

      idle_in();
      m_reset();
      nRST = 1'b0;
      dec_rs_data = 32'hFFFF_FFFF; exm_wen = 1'b1; exm_wsel = 5'd0; exm_data = 32'h1234;
      #3;
      chk("reset ex_valid", 32'(ex_valid), 32'd0);
      chk("reset alu_op", 32'(alu_op), 32'd0);
      chk("reset port_a", alu_port_a, 32'd0);
      chk("reset port_b", alu_port_b, 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      idle_in();
      tick();

      // Forwarding priority table: capture one instruction, then present bypass buses.
      for (int i = 0; i < 7; i++) begin
         idle_in();
         dec_valid = 1'b1; dec_aluop = ALU_ADD; dec_rs = vecs[i].rs; dec_rt = vecs[i].rt;
         dec_rs_data = vecs[i].rsd; dec_rt_data = vecs[i].rtd; dec_imm = vecs[i].imm;
         dec_alusrc = vecs[i].alusrc;
         tick();
         dec_valid = 1'b0;
         exm_wen = vecs[i].e_wen; exm_wsel = vecs[i].e_sel; exm_data = vecs[i].e_data;
         mwb_wen = vecs[i].w_wen; mwb_wsel = vecs[i].w_sel; mwb_data = vecs[i].w_data;
         #2;
         chk($sformatf("vec%0d port_a", i), alu_port_a, vecs[i].exp_a);
         chk($sformatf("vec%0d port_b", i), alu_port_b, vecs[i].exp_b);
         chk($sformatf("vec%0d rt_fwd", i), ex_rt_fwd, vecs[i].exp_rtf);
         tick();
      end

      // Back-to-back dependent ALU ops: EX/MEM bypass, no bubble.
      idle_in();
      dec_valid = 1'b1; dec_aluop = ALU_ADD; dec_rs = 5'd1; dec_rt = 5'd2;
      dec_rs_data = 32'h5; dec_rt_data = 32'h6; dec_wen = 1'b1; dec_wsel = 5'd3;
      tick();
      dec_rs = 5'd3; dec_rs_data = 32'h0; dec_wsel = 5'd4;
      #2 chk("b2b dec_ready", 32'(dec_ready), 32'd1);
      tick();
      dec_valid = 1'b0; exm_wen = 1'b1; exm_wsel = 5'd3; exm_data = 32'h1111;
      #2;
      chk("b2b ex_valid", 32'(ex_valid), 32'd1);
      chk("b2b port_a", alu_port_a, 32'h1111);
      tick();

      // Load-use: one cycle with both ex_valid and dec_ready low, then WB data captured.
      idle_in();
      dec_valid = 1'b1; dec_aluop = ALU_ADD; dec_memread = 1'b1; dec_wen = 1'b1; dec_wsel = 5'd5; dec_rs = 5'd1;
      tick();
      dec_memread = 1'b0; dec_wsel = 5'd6; dec_rs = 5'd5; dec_rt = 5'd1; dec_rs_data = 32'h0; dec_rt_data = 32'h10;
      #2 chk("lu hazard dec_ready", 32'(dec_ready), 32'd0);
      tick();
      #2 chk("lu bubble", {30'd0, ex_valid, dec_ready}, 32'd0);
      tick();
      mwb_wen = 1'b1; mwb_wsel = 5'd5; mwb_data = 32'h5A5A;
      #2 chk("lu release", {30'd0, ex_valid, dec_ready}, 32'd1);
      tick();
      idle_in();
      #2;
      chk("lu ex_valid", 32'(ex_valid), 32'd1);
      chk("lu port_a", alu_port_a, 32'h5A5A);
      chk("lu port_b", alu_port_b, 32'h10);
      tick();

      // Three-cycle stall while MEM/WB retires the held rs.
      idle_in();
      dec_valid = 1'b1; dec_aluop = ALU_XOR; dec_rs = 5'd8; dec_rt = 5'd9;
      dec_rs_data = 32'h1; dec_rt_data = 32'h2; dec_wen = 1'b1; dec_wsel = 5'd10;
      tick();
      dec_aluop = ALU_SUB; dec_rs = 5'd2; dec_wsel = 5'd11; stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         mwb_wen = (c == 0); mwb_wsel = 5'd8; mwb_data = 32'h1234;
         #2 chk("stall held", {29'd0, dec_ready, ex_valid, 1'b0}, 32'd2);
         tick();
      end
      stall = 1'b0; dec_valid = 1'b0; mwb_wen = 1'b0;
      #2;
      chk("stall port_a", alu_port_a, 32'h1234);
      chk("stall port_b", alu_port_b, 32'h2);
      chk("stall alu_op", 32'(alu_op), 32'(ALU_XOR));
      tick();

      // Flush wins over stall.
      idle_in();
      dec_valid = 1'b1; dec_aluop = ALU_OR; dec_rs = 5'd1;
      tick();
      stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0; dec_valid = 1'b0;
      #2 chk("flush+stall ex_valid", 32'(ex_valid), 32'd0);
      tick();

      // Reset asserted mid-bubble.
      idle_in();
      dec_valid = 1'b1; dec_aluop = ALU_ADD; dec_memread = 1'b1; dec_wen = 1'b1; dec_wsel = 5'd5;
      dec_rs = 5'd1; dec_rs_data = 32'hFFFF;
      tick();
      dec_memread = 1'b0; dec_rs = 5'd5; dec_wsel = 5'd6;
      tick();
      #2 nRST = 1'b0;
      #1;
      chk("midreset ex_valid", 32'(ex_valid), 32'd0);
      chk("midreset alu_op", 32'(alu_op), 32'd0);
      chk("midreset ports", alu_port_a | alu_port_b, 32'd0);
      m_reset();
      @(posedge CLK); #1;
      nRST = 1'b1;
      #1 chk("midreset dec_ready", 32'(dec_ready), 32'd1);
      tick();
      idle_in();
      tick();

      for (int e = 0; e < 4; e++) load_use(5'(e + 12), 32'(e + 100));
`ifdef ALU_STAGE_PERF_EN
      #2 chk("bubble_cnt 4 events", 32'(bubble_cnt), 32'(4 * LU));
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         dec_valid   = ($urandom_range(0, 3) != 0);
         dec_aluop   = aluop_t'(4'($urandom_range(0, 9)));
         dec_rs      = 5'($urandom_range(0, 7));
         dec_rt      = 5'($urandom_range(0, 7));
         dec_rs_data = $urandom;
         dec_rt_data = $urandom;
         dec_imm     = $urandom;
         dec_alusrc  = 1'($urandom_range(0, 1));
         dec_wen     = ($urandom_range(0, 3) != 0);
         dec_wsel    = 5'($urandom_range(0, 7));
         dec_memread = ($urandom_range(0, 2) == 0);
         exm_wen     = 1'($urandom_range(0, 1));
         exm_wsel    = 5'($urandom_range(0, 7));
         exm_data    = $urandom;
         mwb_wen     = 1'($urandom_range(0, 1));
         mwb_wsel    = 5'($urandom_range(0, 7));
         mwb_data    = $urandom;
         stall       = ($urandom_range(0, 6) == 0);
         flush       = ($urandom_range(0, 11) == 0);
         tick();
      end
      idle_in();
      tick();
`ifdef ALU_STAGE_PERF_EN
      #2 chk("bubble_cnt total", 32'(bubble_cnt), 32'(bub_seen));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
